// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control step sequencer: state encoding and parameter defaults.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_MEM,
    S_HALT,
    S_ERROR
  } seq_state_t;

  localparam int unsigned DEF_NUM_STEPS      = 8;
  localparam int unsigned DEF_FETCH_STEPS    = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/wait_timer.sv
// Memory-wait counter; expired flags the TIMEOUT_CYCLES-th consecutive enabled cycle.
module wait_timer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || !en) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = en && (cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ctrl_step_sequencer.sv
// Control step sequencer: one-hot T-state generator with memory wait, halt and timeout handling.
module ctrl_step_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter  int unsigned NUM_STEPS      = DEF_NUM_STEPS,
  parameter  int unsigned FETCH_STEPS    = DEF_FETCH_STEPS,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter  int unsigned CNT_W          = 32,
  localparam int unsigned IDX_W          = $clog2(NUM_STEPS)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 end_instr,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic [NUM_STEPS-1:0] step,
  output logic [IDX_W-1:0]     step_idx,
  output logic                 fetch,
  output logic                 stall,
  output logic                 halted,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  seq_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 err_q, err_d;
  logic                 advance;
  logic                 expired;
  logic                 active_d;
  logic                 fetch_d;
  logic [NUM_STEPS-1:0] step_d;

  wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .clr    (clr),
    .en     (state_q == S_WAIT_MEM),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = err_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (run) begin
          state_d = S_RUN;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        pend_d = pend_q | halt_req;
        if (mem_req && !mem_ready) state_d = S_WAIT_MEM;
        else                       advance = 1'b1;
      end
      S_WAIT_MEM: begin
        pend_d = pend_q | halt_req;
        if (mem_ready) begin
          advance = 1'b1;
        end else if (expired) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase

    // A halt request seen in the boundary cycle itself still stops after this instruction.
    if (advance) begin
      if (end_instr || idx_q == LAST_IDX) begin
        idx_d = '0;
        cnt_d = cnt_q + CNT_W'(1);
        if (pend_q || halt_req) begin
          state_d = S_HALT;
          pend_d  = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = S_RUN;
      end
    end
  end

  assign active_d = (state_d == S_RUN) || (state_d == S_WAIT_MEM);
  assign fetch_d  = active_d && (32'(idx_d) < FETCH_STEPS);

  for (genvar g = 0; g < NUM_STEPS; g++) begin : g_dec
    assign step_d[g] = active_d && (idx_d == IDX_W'(g));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      step    <= '0;
      fetch   <= 1'b0;
      stall   <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      step    <= step_d;
      fetch   <= fetch_d;
      stall   <= (state_d == S_WAIT_MEM);
      halted  <= (state_d == S_HALT);
    end
  end

  assign step_idx    = idx_q;
  assign timeout_err = err_q;
  assign instr_count = cnt_q;

endmodule
